// File: rtl/asu_seq.sv
// Sequential add/shift unit: one {mode, x, y} operation per valid/ready transfer.
// Add is nibble-serial over two cycles. Shift moves one bit per cycle. The result is held until out_ready.
module asu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       carry,
  output logic [7:0] out
);

  typedef enum logic [2:0] {IDLE, ADD_LO, ADD_HI, SHIFT, DONE} state_t;

  state_t     state;
  logic [7:0] xr, yr, acc;
  logic [2:0] cnt;
  logic       c;
  logic [4:0] lo_sum, hi_sum;
  logic [7:0] shl;

  assign lo_sum   = {1'b0, xr[3:0]} + {1'b0, yr[3:0]};
  assign hi_sum   = {1'b0, xr[7:4]} + {1'b0, yr[7:4]} + {4'b0, c};
  assign shl      = {acc[6:0], 1'b0};
  assign in_ready = (state == IDLE);

  // acc is the working register. out and carry are loaded only on entry to DONE,
  // so they stay at the previous result while an operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr    <= x;
          yr    <= y;
          acc   <= x;
          cnt   <= y[2:0];
          c     <= 1'b0;
          state <= mode ? SHIFT : ADD_LO;
        end
        ADD_LO: begin
          acc[3:0] <= lo_sum[3:0];
          c        <= lo_sum[4];
          state    <= ADD_HI;
        end
        ADD_HI: begin
          acc[7:4]  <= hi_sum[3:0];
          out       <= {hi_sum[3:0], acc[3:0]};
          carry     <= hi_sum[4];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            acc <= shl;
            cnt <= cnt - 3'd1;
            if (cnt <= 3'd1) begin
              out       <= shl;
              carry     <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            out       <= acc;
            carry     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
